// File: rtl/bus_copy_master_pkg.sv
// rtl/bus_copy_master_pkg.sv - shared state enum, width defaults and bus direction constants
package bus_copy_master_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 32;
    localparam int LW_DEF = 8;

    localparam logic RD_OP = 1'b0;
    localparam logic WR_OP = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RD,
        CAP,
        WR,
        DONE
    } state_e;

endpackage

// File: rtl/bus_copy_master.sv
// rtl/bus_copy_master.sv - block-copy bus initiator (read word, write word, ascending)
// Optional running checksum of copied words: BUS_COPY_MASTER_CHECKSUM_EN
module bus_copy_master
    import bus_copy_master_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] length,
    output logic          busy,
    output logic          done,
`ifdef BUS_COPY_MASTER_CHECKSUM_EN
    output logic [DW-1:0] checksum,
`endif
    output logic          M_req,
    output logic          M_wr,
    output logic [AW-1:0] M_addr,
    output logic [DW-1:0] M_dout,
    input  logic          M_grant,
    input  logic [DW-1:0] M_din
);

    state_e        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] addr_hold_q, addr_hold_d;
    logic [DW-1:0] dout_hold_q, dout_hold_d;
`ifdef BUS_COPY_MASTER_CHECKSUM_EN
    logic [DW-1:0] csum_q, csum_d;
`endif

    logic          req_o;
    logic          wr_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] dout_o;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            addr_hold_q <= '0;
            dout_hold_q <= '0;
`ifdef BUS_COPY_MASTER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            addr_hold_q <= addr_hold_d;
            dout_hold_q <= dout_hold_d;
`ifdef BUS_COPY_MASTER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
`ifdef BUS_COPY_MASTER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        req_o   = 1'b0;
        wr_o    = RD_OP;
        busy    = 1'b0;
        done    = 1'b0;
        // Address/data lines keep their last driven value outside transfer states
        addr_o  = addr_hold_q;
        dout_o  = dout_hold_q;

        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef BUS_COPY_MASTER_CHECKSUM_EN
                    csum_d = '0;
`endif
                    if (length != '0) begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        cnt_d   = length;
                        state_d = REQ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            REQ: begin
                req_o = 1'b1;
                busy  = 1'b1;
                if (M_grant) state_d = RD;
            end
            RD: begin
                req_o  = 1'b1;
                busy   = 1'b1;
                addr_o = src_q;
                if (M_grant) state_d = CAP;
            end
            CAP: begin
                // Read data arrives one cycle after the granted read, so grant is irrelevant here
                req_o   = 1'b1;
                busy    = 1'b1;
                data_d  = M_din;
`ifdef BUS_COPY_MASTER_CHECKSUM_EN
                csum_d  = csum_q + M_din;
`endif
                state_d = WR;
            end
            WR: begin
                req_o  = 1'b1;
                busy   = 1'b1;
                wr_o   = WR_OP;
                addr_o = dst_q;
                dout_o = data_q;
                if (M_grant) begin
                    src_d   = src_q + AW'(1);
                    dst_d   = dst_q + AW'(1);
                    cnt_d   = cnt_q - LW'(1);
                    state_d = (cnt_q != LW'(1)) ? RD : DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        addr_hold_d = addr_o;
        dout_hold_d = dout_o;
    end

    assign M_req  = req_o;
    assign M_wr   = wr_o;
    assign M_addr = addr_o;
    assign M_dout = dout_o;
`ifdef BUS_COPY_MASTER_CHECKSUM_EN
    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_bus_copy_master.sv
// tb/tb_bus_copy_master.sv - directed table-driven bench for bus_copy_master with a RAM slave model
module tb_bus_copy_master;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  src_addr;
    logic [7:0]  dst_addr;
    logic [7:0]  length;
    logic        busy;
    logic        done;
    logic        M_req;
    logic        M_wr;
    logic [7:0]  M_addr;
    logic [31:0] M_dout;
    logic        M_grant;
    logic [31:0] M_din;
`ifdef BUS_COPY_MASTER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] mem [256];
    logic [31:0] rdata;

    int n_checks;
    int n_fail;

    bus_copy_master dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
`ifdef BUS_COPY_MASTER_CHECKSUM_EN
        .checksum (checksum),
`endif
        .M_req    (M_req),
        .M_wr     (M_wr),
        .M_addr   (M_addr),
        .M_dout   (M_dout),
        .M_grant  (M_grant),
        .M_din    (M_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM slave: write data in the write cycle, read data one cycle later
    always @(posedge clk) begin
        if (M_req && M_grant) begin
            if (M_wr) mem[M_addr] <= M_dout;
            else      rdata <= mem[M_addr];
        end
    end
    assign M_din = rdata;

    typedef struct {
        logic [7:0] src;
        logic [7:0] dst;
        logic [7:0] len;
        int         exp_cyc;
        bit         stall;
        string      name;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v, input int idx, input bit fill);
        logic [31:0] expw [256];
        logic [7:0]  a;
        int first_done, done_cnt, busy_err, req_gap, req_seen, wr_err;
        first_done = 0; done_cnt = 0; busy_err = 0; req_gap = 0; req_seen = 0; wr_err = 0;
        for (int i = 0; i < int'(v.len); i++) begin
            a = v.src + 8'(i);
            if (fill) mem[a] = 32'hA0 + 32'(i) + 32'(idx * 16);
            expw[i] = mem[a];
        end
        for (int i = 0; i < int'(v.len); i++) begin
            a = v.dst + 8'(i);
            mem[a] = 32'h0;
        end
        @(negedge clk);
        start = 1'b1; src_addr = v.src; dst_addr = v.dst; length = v.len;
        for (int k = 1; k <= v.exp_cyc + 1; k++) begin
            @(negedge clk);
            start = 1'b0;
            M_grant = !(v.stall && (k == 2 || k == 3 || k == 4 || k == 7 || k == 8));
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = k;
            end
            if (busy !== (k < v.exp_cyc)) busy_err++;
            if (M_req) req_seen++;
            if (k < v.exp_cyc && !M_req) req_gap++;
            if (!M_req && M_wr) wr_err++;
        end
        M_grant = 1'b1;
        check({v.name, " done_cycle"}, 64'(first_done), 64'(v.exp_cyc));
        check({v.name, " done_pulses"}, 64'(done_cnt), 64'd1);
        check({v.name, " busy_window_errors"}, 64'(busy_err), 64'd0);
        check({v.name, " wr_without_req"}, 64'(wr_err), 64'd0);
        if (v.len == 8'd0) check({v.name, " req_cycles"}, 64'(req_seen), 64'd0);
        else               check({v.name, " req_gaps"}, 64'(req_gap), 64'd0);
        for (int i = 0; i < int'(v.len); i++) begin
            a = v.dst + 8'(i);
            check($sformatf("%s dst[%0h]", v.name, a), 64'(mem[a]), 64'(expw[i]));
        end
    endtask

    initial begin
        vec_t r;
        int stray_done, stray_req;
        n_checks = 0; n_fail = 0;
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
        M_grant = 1'b1; rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        vecs[0] = '{8'h00, 8'h10, 8'd4, 14, 1'b0, "basic"};
        vecs[1] = '{8'hFE, 8'h20, 8'd3, 11, 1'b0, "wrap"};
        vecs[2] = '{8'h40, 8'h50, 8'd1, 5, 1'b0, "single"};
        vecs[3] = '{8'h80, 8'h90, 8'd0, 1, 1'b0, "zero_len"};
        vecs[4] = '{8'h30, 8'h38, 8'd2, 13, 1'b1, "stall"};

        #1;
        check("rst M_req", 64'(M_req), 64'd0);
        check("rst M_wr", 64'(M_wr), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst M_addr", 64'(M_addr), 64'd0);
        check("rst M_dout", 64'(M_dout), 64'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        for (int j = 0; j < 5; j++) run_job(vecs[j], j, 1'b1);

        // Reset asserted during CAP of a two-word job
        mem[8'h60] = 32'h1111_0001; mem[8'h61] = 32'h1111_0002;
        mem[8'h70] = 32'h0; mem[8'h71] = 32'h0;
        @(negedge clk);
        start = 1'b1; src_addr = 8'h60; dst_addr = 8'h70; length = 8'd2;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst M_req", 64'(M_req), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        stray_done = 0; stray_req = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) stray_done++;
            if (M_req) stray_req++;
        end
        check("midrst stray_done", 64'(stray_done), 64'd0);
        check("midrst stray_req", 64'(stray_req), 64'd0);
        check("midrst dst untouched", 64'(mem[8'h70]), 64'd0);
        r = '{8'h60, 8'h70, 8'd2, 8, 1'b0, "after_rst"};
        run_job(r, 0, 1'b0);

        // start while busy must not restart or retarget the job
        mem[8'hA0] = 32'h5A5A_0001;
        mem[8'hB0] = 32'h0; mem[8'hC8] = 32'h0;
        @(negedge clk);
        start = 1'b1; src_addr = 8'hA0; dst_addr = 8'hB0; length = 8'd1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        start = 1'b1; src_addr = 8'hA8; dst_addr = 8'hC8; length = 8'd1;
        @(negedge clk); start = 1'b0;
        stray_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) stray_done++;
        end
        check("busy_start dst", 64'(mem[8'hB0]), 64'h5A5A_0001);
        check("busy_start ignored dst", 64'(mem[8'hC8]), 64'd0);
        check("busy_start done_pulses", 64'(stray_done), 64'd1);

`ifdef BUS_COPY_MASTER_CHECKSUM_EN
        mem[8'hD0] = 32'hFFFF_FFFF; mem[8'hD1] = 32'h0000_0002;
        r = '{8'hD0, 8'hE0, 8'd2, 8, 1'b0, "csum"};
        run_job(r, 0, 1'b0);
        check("checksum", 64'(checksum), 64'h0000_0001);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_copy_master.md
Name: bus_copy_master

Overview:
- Bus initiator for the shared master port of the system bus; it drives the request/write/address/data lines and consumes the grant and read-data lines.
- Executes block-copy jobs: reads `length` words starting at `src_addr` and writes them to `dst_addr` upward, one word at a time.
- Sits in front of the bus in place of an external master, so the RAM and ALU slaves can be loaded and unloaded without host involvement.

Parameters:
- AW, 8, bus address width
- DW, 32, bus data width
- LW, 8, job length counter width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle job launch; sampled only in IDLE
- src_addr  in  AW  first source word address
- dst_addr  in  AW  first destination word address
- length  in  LW  word count, 0..255
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at job end
- M_req  out  1  bus request
- M_wr  out  1  1 = write, 0 = read
- M_addr  out  AW  transfer address
- M_dout  out  DW  write data driven to the bus
- M_grant  in  1  bus grant
- M_din  in  DW  read data from the bus

Behaviour:
- Reset: all outputs 0; FSM = IDLE; internal address registers, count and data latch = 0.
- Bus rules:
  - A transfer occurs only in a cycle where M_req=1 and M_grant=1.
  - Write: M_addr and M_dout are valid in the same cycle as M_wr=1.
  - Read: M_addr is valid with M_wr=0; M_din is valid in the following cycle.
- FSM states:
  - IDLE: start=1 and length≠0 latches src_addr, dst_addr and length, then goes to REQ. start=1 and length=0 goes to DONE with no bus activity. start=0 stays in IDLE.
  - REQ: M_req=1, M_wr=0. Goes to RD when M_grant=1.
  - RD: M_req=1, M_wr=0, M_addr=src pointer. Goes to CAP if M_grant=1; otherwise stays in RD.
  - CAP: M_req=1, no transfer. Latches M_din into the data register. Goes to WR.
  - WR: M_req=1, M_wr=1, M_addr=dst pointer, M_dout=latched data. If M_grant=1, both pointers increment and count decrements; then go to RD if count≠1, else DONE. If M_grant=0, stay in WR.
  - DONE: M_req=0, done=1 for exactly one cycle, then IDLE.
- Timing: with grant held high, a job of N words takes 1 + 3N bus-active cycles, and done follows in the next cycle.
- Arithmetic:
  - Pointers increment modulo 2^AW (0xFF+1 wraps to 0x00).
  - No overlap detection; the copy is always ascending.
- Signal rules:
  - busy=1 in REQ, RD, CAP and WR; busy=0 in IDLE and DONE.
  - M_wr=0 whenever M_req=0.
  - M_addr and M_dout hold their last values when not transferring.
- Boundary conditions:
  - start while busy: ignored.
  - Grant dropped mid-job: the FSM holds in its current state and M_req stays high.
  - Grant dropped in CAP: no effect, because the read already completed.
- Reset mid-job: returns to IDLE immediately; M_req drops asynchronously; no done pulse.

Optional Feature:
- Macro: BUS_COPY_MASTER_CHECKSUM_EN
- When defined:
  - Adds output `checksum` (DW bits).
  - checksum clears on an accepted start.
  - checksum adds each latched word modulo 2^DW in CAP.
  - checksum is stable from done until the next start; it resets to 0.
- When undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, REQ, RD, CAP, WR, DONE);
  - AW, DW and LW defaults;
  - the bus direction constants RD_OP=0 and WR_OP=1.
- No sub-module is warranted; the FSM, pointers and counter fit in one module.

Test Plan:
- Basic copy: grant tied to 1; src=0x00, dst=0x10, length=4, RAM[0..3]=0xA0..0xA3 → RAM[0x10..0x13]=0xA0..0xA3; done is pulsed exactly 14 cycles after start.
- Zero-length job: start with length=0 → done pulses the next cycle; M_req never asserts.
- Grant stall: during length=2, grant is forced low for 3 cycles in RD and 2 cycles in WR → same data is copied; total is 5 cycles longer; M_req stays high throughout.
- Address wrap: src=0xFE, dst=0x20, length=3 → reads 0xFE, 0xFF, 0x00 in order; the destination holds them at 0x20..0x22.
- Reset mid-job: assert reset in a CAP cycle → M_req=0 and busy=0 immediately; no done pulse; the next job runs correctly.
- Checksum (macro defined): copy words 0xFFFFFFFF and 0x00000002 → checksum=0x00000001.
